// File: rtl/regs_wb_arb.sv
// ---------------------------------------------------------------------------
// regs_wb_arb
//
// Arbitrates the single register-file write port between two writeback
// sources and tracks which registers still have a long-latency result in
// flight.
//
// Sources:
//   EX  - single-cycle execute results. Preferred when both sources request.
//   LSU - long-latency results (loads, multi-cycle ops). It may be passed
//         over while EX is busy. After STARVE_MAX consecutive denied
//         cycles it is forced to win.
//
// Scoreboard:
//   ID marks a destination pending (sb_set_i) when it issues a long-latency
//   op. The bit is cleared when the LSU writeback for that register is
//   accepted. Decode queries the vector through rs1/rs2_busy_o.
//
// Ports:
//   clk, rst              clock; asynchronous active-low reset
//   ex_valid_i/waddr/wdata EX writeback request
//   ex_ready_o            EX accepted this cycle (combinational)
//   lsu_valid_i/waddr/wdata LSU writeback request
//   lsu_ready_o           LSU accepted this cycle (combinational)
//   reg_wen_o/waddr/wdata registered register-file write port
//   sb_set_i/sb_set_addr_i mark a destination register pending
//   rs1/rs2_raddr_i       source registers being decoded
//   rs1/rs2_busy_o        source has an outstanding LSU write
// ---------------------------------------------------------------------------
module regs_wb_arb #(
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        ex_valid_i,
  input  logic [4:0]  ex_waddr_i,
  input  logic [63:0] ex_wdata_i,
  output logic        ex_ready_o,

  input  logic        lsu_valid_i,
  input  logic [4:0]  lsu_waddr_i,
  input  logic [63:0] lsu_wdata_i,
  output logic        lsu_ready_o,

  output logic        reg_wen_o,
  output logic [4:0]  reg_waddr_o,
  output logic [63:0] reg_wdata_o,

  input  logic        sb_set_i,
  input  logic [4:0]  sb_set_addr_i,

  input  logic [4:0]  rs1_raddr_i,
  input  logic [4:0]  rs2_raddr_i,
  output logic        rs1_busy_o,
  output logic        rs2_busy_o
);

  // The starve counter saturates at this value, so 4 bits cover 1..15.
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [3:0]  r_starve_cnt;
  logic        r_wen;
  logic [4:0]  r_waddr;
  logic [63:0] r_wdata;
  logic [31:0] r_busy;

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  logic        w_lsu_force;
  logic        w_grant_lsu;
  logic        w_grant_ex;
  logic        w_accept;
  logic [4:0]  w_win_addr;
  logic [63:0] w_win_data;

  // LSU wins outright when EX is idle. When both request, it wins only
  // after being denied STARVE_MAX cycles in a row.
  assign w_lsu_force = (r_starve_cnt == STARVE_LIM);
  assign w_grant_lsu = lsu_valid_i & (~ex_valid_i | w_lsu_force);
  assign w_grant_ex  = ex_valid_i & ~w_grant_lsu;

  // Ready is gated by reset so both go low as soon as rst falls, without
  // waiting for a clock edge. That also discards any handshake in progress.
  assign ex_ready_o  = rst & w_grant_ex;
  assign lsu_ready_o = rst & w_grant_lsu;
  assign w_accept    = ex_ready_o | lsu_ready_o;

  assign w_win_addr  = lsu_ready_o ? lsu_waddr_i : ex_waddr_i;
  assign w_win_data  = lsu_ready_o ? lsu_wdata_i : ex_wdata_i;

  // Counts consecutive cycles in which the LSU asked and was refused.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve_cnt <= 4'd0;
    end else if (lsu_ready_o) begin
      r_starve_cnt <= 4'd0;
    end else if (lsu_valid_i && (r_starve_cnt != STARVE_LIM)) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Register-file write port
  // -------------------------------------------------------------------------
  // A write to x0 still completes the handshake but never reaches the
  // register file. Address and data keep their last real write, so the
  // port only moves when a write is actually performed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wen   <= 1'b0;
      r_waddr <= 5'd0;
      r_wdata <= 64'd0;
    end else begin
      r_wen <= w_accept && (w_win_addr != 5'd0);
      if (w_accept && (w_win_addr != 5'd0)) begin
        r_waddr <= w_win_addr;
        r_wdata <= w_win_data;
      end
    end
  end

  assign reg_wen_o   = r_wen;
  assign reg_waddr_o = r_waddr;
  assign reg_wdata_o = r_wdata;

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  logic [31:0] w_set_dec;
  logic [31:0] w_clr_dec;
  logic [31:0] w_busy_next;

  // One-hot decode of the set and clear targets. x0 can never be pending,
  // so its bit is tied off and a set aimed at address 0 is ignored.
  for (genvar gi = 0; gi < 32; gi++) begin : g_busy_dec
    if (gi == 0) begin : g_x0
      assign w_set_dec[gi] = 1'b0;
      assign w_clr_dec[gi] = 1'b0;
    end else begin : g_xn
      assign w_set_dec[gi] = sb_set_i & (sb_set_addr_i == 5'(gi));
      assign w_clr_dec[gi] = lsu_ready_o & (lsu_waddr_i == 5'(gi));
    end
  end

  // The set is applied after the clear. If ID issues a new long-latency op
  // to the register whose previous result is retiring in the same cycle,
  // the register stays pending.
  assign w_busy_next = (r_busy & ~w_clr_dec) | w_set_dec;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= 32'd0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  // Reads come from registered state only. x0 always reads not-busy.
  assign rs1_busy_o = rst & (rs1_raddr_i != 5'd0) & r_busy[rs1_raddr_i];
  assign rs2_busy_o = rst & (rs2_raddr_i != 5'd0) & r_busy[rs2_raddr_i];

endmodule

// File: doc/regs_wb_arb.md
REGS_WB_ARB -- requirements
Module: regs_wb_arb

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 3, range 1..15: max consecutive cycles LSU may be denied before it is forced to win.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ex_valid_i  input  1  EX writeback request.
REQ-005 SHALL have port ex_waddr_i  input  5  EX destination register.
REQ-006 SHALL have port ex_wdata_i  input  64  EX writeback data.
REQ-007 SHALL have port ex_ready_o  output  1  EX request accepted this cycle.
REQ-008 SHALL have port lsu_valid_i  input  1  LSU/long-latency writeback request.
REQ-009 SHALL have port lsu_waddr_i  input  5  LSU destination register.
REQ-010 SHALL have port lsu_wdata_i  input  64  LSU writeback data.
REQ-011 SHALL have port lsu_ready_o  output  1  LSU request accepted this cycle.
REQ-012 SHALL have port reg_wen_o  output  1  register-file write enable, registered.
REQ-013 SHALL have port reg_waddr_o  output  5  register-file write address, registered.
REQ-014 SHALL have port reg_wdata_o  output  64  register-file write data, registered.
REQ-015 SHALL have port sb_set_i  input  1  ID issues a long-latency op; mark destination pending.
REQ-016 SHALL have port sb_set_addr_i  input  5  destination to mark pending.
REQ-017 SHALL have ports rs1_raddr_i, rs2_raddr_i  input  5 each  source registers being decoded.
REQ-018 SHALL have ports rs1_busy_o, rs2_busy_o  output  1 each  source has an outstanding LSU write.

Function
REQ-019 SHALL accept a request on the cycle valid && ready; accepted data goes out next cycle.
REQ-020 SHALL drive ready combinationally; at most one of ex_ready_o/lsu_ready_o high per cycle, never high unless that valid is high.
REQ-021 SHALL grant EX when only EX valid, LSU when only LSU valid, none when neither valid.
REQ-022 SHALL grant EX when both valid, unless starve counter == STARVE_MAX, then grant LSU.
REQ-023 SHALL increment starve counter (saturating at STARVE_MAX) each cycle lsu_valid_i && !lsu_ready_o; clear it to 0 on LSU acceptance; hold otherwise.
REQ-024 SHALL, on accept, register reg_waddr_o/reg_wdata_o from the winner and set reg_wen_o=1 for exactly one cycle; reg_wen_o=0 in cycles following no acceptance.
REQ-025 SHALL accept writes to x0 (ready asserted normally) but keep reg_wen_o=0 for them.
REQ-026 SHALL hold reg_waddr_o/reg_wdata_o at last values when reg_wen_o=0.
REQ-027 SHALL keep a 32-bit busy vector; sb_set_i with sb_set_addr_i!=0 sets that bit next cycle; sb_set_i with address 0 ignored.
REQ-028 SHALL clear busy bit lsu_waddr_i on LSU acceptance, effective next cycle (same cycle reg_wen_o asserts).
REQ-029 SHALL let set win when set and clear target the same bit in one cycle; set and clear of different bits both apply.
REQ-030 SHALL drive rsN_busy_o = busy[rsN_raddr_i] combinationally from registered state; 0 for address 0.
REQ-031 SHALL not clear busy on EX acceptance.

Reset
REQ-032 SHALL, while rst=0, force reg_wen_o=0, reg_waddr_o=0, reg_wdata_o=0, busy vector=0, starve counter=0, ex_ready_o=0, lsu_ready_o=0, rs1/rs2_busy_o=0, asynchronously.
REQ-033 SHALL discard any acceptance in progress when reset asserts mid-operation; first grant possible on first posedge after rst rises.

Verification
REQ-034 SHALL cover: EX only, waddr=5, wdata=0xDEAD -> ex_ready_o=1 same cycle; next cycle reg_wen_o=1, reg_waddr_o=5, reg_wdata_o=0xDEAD; cycle after reg_wen_o=0.
REQ-035 SHALL cover: EX and LSU both held valid, STARVE_MAX=3 -> EX granted cycles 0-2, LSU granted cycle 3, counter back to 0, EX granted cycle 4.
REQ-036 SHALL cover: LSU write to x0 -> lsu_ready_o=1, next cycle reg_wen_o=0.
REQ-037 SHALL cover: sb_set_i addr=7; next cycle rs1_raddr_i=7 -> rs1_busy_o=1; LSU accepts waddr=7 -> following cycle rs1_busy_o=0 with reg_wen_o=1, reg_waddr_o=7.
REQ-038 SHALL cover: sb_set_i addr=9 same cycle LSU accepts waddr=9 -> busy[9]=1 next cycle.
REQ-039 SHALL cover: rst driven low mid-stream between clock edges -> reg_wen_o, ready outputs, busy outputs go 0 immediately without a clock edge.
